// File: rtl/shift_deserializer_pkg.sv
// rtl/shift_deserializer_pkg.sv - shared encodings for the serial link receive end
package shift_deserializer_pkg;

   localparam logic DIR_LSB_FIRST = 1'b0;
   localparam logic DIR_MSB_FIRST = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_e;

   // Mode encodings of the transmitting universal shift register
   typedef enum logic [1:0] {
      USR_HOLD        = 2'd0,
      USR_SHIFT_RIGHT = 2'd1,
      USR_SHIFT_LEFT  = 2'd2,
      USR_LOAD        = 2'd3
   } usr_mode_e;

   function automatic usr_mode_e usr_mode_for_dir(input logic dir);
      return (dir == DIR_MSB_FIRST) ? USR_SHIFT_LEFT : USR_SHIFT_RIGHT;
   endfunction

endpackage

// File: rtl/deser_shift_core.sv
// rtl/deser_shift_core.sv - bidirectional shift register with enable and clear
module deser_shift_core
   import shift_deserializer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             dir,
   input  logic             bit_in,
   output logic [WIDTH-1:0] word_next
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (clr) begin
         shreg_d = '0;
      end else if (en) begin
         if (dir == DIR_MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], bit_in};
         end else begin
            shreg_d = {bit_in, shreg_q[WIDTH-1:1]};
         end
      end
   end

   // The top captures the word including the final bit from the next-state value
   assign word_next = shreg_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-to-parallel receiver with one-word output holding register
module shift_deserializer
   import shift_deserializer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dir,
   input  logic             ser_in,
   input  logic             ser_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q, overrun_d;

   logic             shift_en;
   logic             shift_clr;
   logic             frame_done;
   logic [WIDTH-1:0] word_next;

   deser_shift_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .en       (shift_en),
      .clr      (shift_clr),
      .dir      (dir_q),
      .bit_in   (ser_in),
      .word_next(word_next)
   );

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;
      shift_en    = 1'b0;
      shift_clr   = 1'b0;
      frame_done  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RECV;
               dir_d     = dir;
               cnt_d     = '0;
               shift_clr = 1'b1;
            end
         end
         RECV: begin
            if (ser_valid) begin
               shift_en = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A slot being consumed this edge counts as free for the new word
      if (frame_done) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = word_next;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         dir_q       <= DIR_LSB_FIRST;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == RECV);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - directed table-driven bench for shift_deserializer
module tb_shift_deserializer;
   import shift_deserializer_pkg::*;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             dir;
   logic             ser_in;
   logic             ser_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             overrun;

   int n_checks = 0;
   int n_pass   = 0;

   shift_deserializer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dir      (dir),
      .ser_in   (ser_in),
      .ser_valid(ser_valid),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst_n;
      logic       start;
      logic       dir;
      logic       ser_in;
      logic       ser_valid;
      logic       out_ready;
      logic [3:0] exp_data;
      logic       exp_valid;
      logic       exp_busy;
      logic       exp_ovr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic r, input logic s, input logic d,
                               input logic si, input logic sv, input logic rdy,
                               input logic [3:0] ed, input logic ev, input logic eb,
                               input logic eo);
      vec_t v;
      v.name = name; v.rst_n = r; v.start = s; v.dir = d; v.ser_in = si;
      v.ser_valid = sv; v.out_ready = rdy; v.exp_data = ed; v.exp_valid = ev;
      v.exp_busy = eb; v.exp_ovr = eo;
      return v;
   endfunction

   task automatic check(input string name, input string field, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s %s: got %0h expected %0h", name, field, act, exp);
   endtask

   // Drive one cycle of inputs, let one rising edge pass, then compare outputs
   task automatic step(input vec_t v);
      rst = v.rst_n; start = v.start; dir = v.dir; ser_in = v.ser_in;
      ser_valid = v.ser_valid; out_ready = v.out_ready;
      @(posedge clk);
      #1;
      check(v.name, "out_data", 32'(out_data), 32'(v.exp_data));
      check(v.name, "out_valid", 32'(out_valid), 32'(v.exp_valid));
      check(v.name, "busy", 32'(busy), 32'(v.exp_busy));
      check(v.name, "overrun", 32'(overrun), 32'(v.exp_ovr));
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; dir = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; out_ready = 1'b0;
      #1;

      //          name        rst st dir si sv rdy  data     v  b  o
      vecs.push_back(mk("reset",     0, 0, 0, 0, 0, 0, 4'h0,    0, 0, 0));
      vecs.push_back(mk("idle_sv",   1, 0, 0, 1, 1, 0, 4'h0,    0, 0, 0));
      vecs.push_back(mk("t1_start",  1, 1, DIR_LSB_FIRST, 0, 0, 0, 4'h0, 0, 1, 0));
      vecs.push_back(mk("t1_b1",     1, 0, 0, 1, 1, 0, 4'h0,    0, 1, 0));
      vecs.push_back(mk("t1_b2",     1, 0, 0, 0, 1, 0, 4'h0,    0, 1, 0));
      vecs.push_back(mk("t1_b3",     1, 0, 0, 1, 1, 0, 4'h0,    0, 1, 0));
      vecs.push_back(mk("t1_b4",     1, 0, 0, 1, 1, 0, 4'b1101, 1, 0, 0));
      vecs.push_back(mk("t1_hold",   1, 0, 0, 0, 0, 0, 4'b1101, 1, 0, 0));
      vecs.push_back(mk("t1_take",   1, 0, 0, 0, 0, 1, 4'b1101, 0, 0, 0));
      vecs.push_back(mk("t2_start",  1, 1, DIR_MSB_FIRST, 0, 0, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t2_b1",     1, 0, 0, 1, 1, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t2_b2",     1, 0, 0, 1, 1, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t2_gap1",   1, 0, 0, 1, 0, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t2_gap2",   1, 0, 0, 1, 0, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t2_b3",     1, 0, 0, 0, 1, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t2_b4",     1, 0, 0, 1, 1, 0, 4'b1101, 1, 0, 0));
      vecs.push_back(mk("t2_take",   1, 0, 0, 0, 0, 1, 4'b1101, 0, 0, 0));
      vecs.push_back(mk("t3_start",  1, 1, DIR_LSB_FIRST, 0, 0, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t3_b1",     1, 0, 0, 1, 1, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t3_b2",     1, 0, 0, 0, 1, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t3_b3",     1, 0, 0, 0, 1, 0, 4'b1101, 0, 1, 0));
      vecs.push_back(mk("t3_b4",     1, 0, 0, 0, 1, 0, 4'b0001, 1, 0, 0));
      vecs.push_back(mk("t3_start2", 1, 1, DIR_LSB_FIRST, 0, 0, 0, 4'b0001, 1, 1, 0));
      vecs.push_back(mk("t3_c1",     1, 0, 0, 1, 1, 0, 4'b0001, 1, 1, 0));
      vecs.push_back(mk("t3_c2",     1, 0, 0, 0, 1, 0, 4'b0001, 1, 1, 0));
      vecs.push_back(mk("t3_c3",     1, 0, 0, 1, 1, 0, 4'b0001, 1, 1, 0));
      vecs.push_back(mk("t3_ovr",    1, 0, 0, 1, 1, 0, 4'b0001, 1, 0, 1));
      vecs.push_back(mk("t3_take",   1, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 1));
      vecs.push_back(mk("t3_sticky", 1, 0, 0, 0, 0, 1, 4'b0001, 0, 0, 1));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

      // Consume on the completion edge; second frame starts right after the first
      step(mk("t4_reset",  0, 0, 0, 0, 0, 0, 4'h0,    0, 0, 0));
      step(mk("t4_start",  1, 1, DIR_MSB_FIRST, 0, 0, 0, 4'h0, 0, 1, 0));
      step(mk("t4_a1",     1, 0, 0, 0, 1, 0, 4'h0,    0, 1, 0));
      step(mk("t4_a2",     1, 0, 0, 0, 1, 0, 4'h0,    0, 1, 0));
      step(mk("t4_a3",     1, 0, 0, 0, 1, 0, 4'h0,    0, 1, 0));
      step(mk("t4_a4",     1, 0, 0, 1, 1, 0, 4'b0001, 1, 0, 0));
      step(mk("t4_start2", 1, 1, DIR_LSB_FIRST, 0, 0, 0, 4'b0001, 1, 1, 0));
      step(mk("t4_b1",     1, 0, 0, 1, 1, 0, 4'b0001, 1, 1, 0));
      step(mk("t4_b2",     1, 0, 0, 0, 1, 0, 4'b0001, 1, 1, 0));
      step(mk("t4_b3",     1, 0, 0, 1, 1, 0, 4'b0001, 1, 1, 0));
      step(mk("t4_b4",     1, 0, 0, 1, 1, 1, 4'b1101, 1, 0, 0));
      step(mk("t4_hold",   1, 0, 0, 0, 0, 0, 4'b1101, 1, 0, 0));

      // Mid-frame reset drops both partial and pending words
      step(mk("t5_start",  1, 1, DIR_LSB_FIRST, 0, 0, 0, 4'b1101, 1, 1, 0));
      step(mk("t5_b1",     1, 0, 0, 1, 1, 0, 4'b1101, 1, 1, 0));
      step(mk("t5_b2",     1, 0, 0, 1, 1, 0, 4'b1101, 1, 1, 0));
      step(mk("t5_rst",    0, 0, 0, 1, 1, 0, 4'h0,    0, 0, 0));
      step(mk("t5_start2", 1, 1, DIR_LSB_FIRST, 0, 0, 0, 4'h0, 0, 1, 0));
      step(mk("t5_c1",     1, 0, 0, 0, 1, 0, 4'h0,    0, 1, 0));
      step(mk("t5_c2",     1, 0, 0, 1, 1, 0, 4'h0,    0, 1, 0));
      step(mk("t5_c3",     1, 0, 0, 1, 1, 0, 4'h0,    0, 1, 0));
      step(mk("t5_c4",     1, 0, 0, 0, 1, 0, 4'b0110, 1, 0, 0));
      step(mk("t5_take",   1, 0, 0, 0, 0, 1, 4'b0110, 0, 0, 0));

      // start pulses and dir changes inside RECV, ser_valid in IDLE
      step(mk("t6_start",  1, 1, DIR_MSB_FIRST, 0, 0, 0, 4'b0110, 0, 1, 0));
      step(mk("t6_b1",     1, 1, 0, 1, 1, 0, 4'b0110, 0, 1, 0));
      step(mk("t6_gap",    1, 1, 0, 1, 0, 0, 4'b0110, 0, 1, 0));
      step(mk("t6_b2",     1, 0, 0, 0, 1, 0, 4'b0110, 0, 1, 0));
      step(mk("t6_b3",     1, 1, 0, 1, 1, 0, 4'b0110, 0, 1, 0));
      step(mk("t6_b4",     1, 0, 0, 1, 1, 0, 4'b1011, 1, 0, 0));
      step(mk("t6_idle_sv",1, 0, 0, 0, 1, 0, 4'b1011, 1, 0, 0));
      step(mk("t6_idle_sv2",1,0, 0, 1, 1, 0, 4'b1011, 1, 0, 0));
      step(mk("t6_rdy_new",1, 1, DIR_LSB_FIRST, 0, 0, 1, 4'b1011, 0, 1, 0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
